// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Holds the FSM encoding, parity sense and counter-width helper.
package sipo_pkg;

  typedef enum logic [0:0] {
    S_SHIFT = 1'b0,
    S_PAR   = 1'b1
  } state_t;

  localparam int EVEN_PARITY = 0;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/d_ff_en_rst.sv
// One-bit D flip-flop cell with enable and synchronous active-low reset.
// Provides true and complement outputs.
module d_ff_en_rst (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qbar
);

  // Reset dominates enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with valid/ready output and overrun flag.
// Define SIPO_PARITY_EN to append and check an even-parity bit per word.
import sipo_pkg::*;

module sipo_deserializer #(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

  logic             acc;
  logic             last;
  logic             sh_en;
  logic             sh_clr_n;
  logic             done;
  logic             load_ok;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] word;

  assign acc      = sin_valid && !frame_clr;
  assign last     = (bit_cnt == CW'(WIDTH - 1));
  assign sh_clr_n = rst_n && !frame_clr;
  assign load_ok  = !pout_valid || pout_ready;

  // Both cell outputs carry the same bit; combine them into the word.
  assign sh = q & ~qn;

  // Next shift-register value for either bit order.
  always_comb begin
    sh_nxt = sh;
    if (MSB_FIRST) begin
      sh_nxt = (sh << 1) | WIDTH'(sin);
    end else begin
      sh_nxt = (sh >> 1) | {sin, (WIDTH-1)'(0)};
    end
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_chain
      d_ff_en_rst u_ff (
        .clk  (clk),
        .rst_n(sh_clr_n),
        .en   (sh_en),
        .d    (sh_nxt[i]),
        .q    (q[i]),
        .qbar (qn[i])
      );
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  state_t state;
  state_t state_nxt;
  logic   word_perr;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_SHIFT;
    end else begin
      state <= state_nxt;
    end
  end

  // Data bits shift in S_SHIFT; the parity bit completes in S_PAR.
  always_comb begin
    state_nxt = state;
    sh_en     = 1'b0;
    done      = 1'b0;
    word      = sh;
    word_perr = 1'b0;
    unique case (state)
      S_SHIFT: begin
        sh_en = acc;
        if (acc && last) begin
          state_nxt = S_PAR;
        end
      end
      S_PAR: begin
        if (acc) begin
          done      = 1'b1;
          word_perr = ^sh ^ sin ^ 1'(EVEN_PARITY);
          state_nxt = S_SHIFT;
        end
      end
      default: state_nxt = S_SHIFT;
    endcase
    if (frame_clr) begin
      state_nxt = S_SHIFT;
    end
  end

  // Parity result follows the held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (done && load_ok) begin
      parity_err <= word_perr;
    end else if (pout_valid && pout_ready) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign sh_en      = acc;
  assign done       = acc && last;
  assign word       = sh_nxt;
  assign parity_err = 1'b0;
`endif

  // Bit counter; frame_clr aborts the partial word.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_clr) begin
      bit_cnt <= '0;
    end else if (acc) begin
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
    end
  end

  // Holding register with handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done && load_ok) begin
        pout       <= word;
        pout_valid <= 1'b1;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
      if (done && !load_ok) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer, MSB-first and LSB-first instances.
// Table-driven words plus hand sequences for handshake and abort cases.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       frame_clr = 1'b0;
  logic       pout_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] pout;
  logic [7:0] pout_l;
  logic       pv;
  logic       pv_l;
  logic [3:0] bc;
  logic [3:0] bc_l;
  logic       ovr;
  logic       ovr_l;
  logic       pe;
  logic       pe_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bits;
    logic [7:0] msb;
    logic [7:0] lsb;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .frame_clr(frame_clr), .pout(pout), .pout_valid(pv),
    .pout_ready(pout_ready), .bit_cnt(bc), .overrun(ovr),
    .ovr_clr(ovr_clr), .parity_err(pe)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .frame_clr(frame_clr), .pout(pout_l), .pout_valid(pv_l),
    .pout_ready(pout_ready), .bit_cnt(bc_l), .overrun(ovr_l),
    .ovr_clr(ovr_clr), .parity_err(pe_l)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] w, input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
      if (i == 0 && rdy_last) pout_ready = 1'b1;
`endif
      send_bit(w[i]);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy_last);
    send_data(w, rdy_last);
`ifdef SIPO_PARITY_EN
    if (rdy_last) pout_ready = 1'b1;
    send_bit(^w);
`endif
  endtask

  initial begin
    tbl[0] = '{8'hB2, 8'hB2, 8'h4D};
    tbl[1] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[2] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[4] = '{8'h01, 8'h01, 8'h80};
    tbl[5] = '{8'h80, 8'h80, 8'h01};
    tbl[6] = '{8'hC4, 8'hC4, 8'h23};

    // reset state
    tick();
    tick();
    chk("rst_pv", 32'(pv), 0);
    chk("rst_pout", 32'(pout), 0);
    chk("rst_bc", 32'(bc), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_pe", 32'(pe), 0);
    rst_n = 1'b1;
    pout_ready = 1'b1;

    // table words with ready held high
    for (int k = 0; k < 7; k++) begin
      send_word(tbl[k].bits, 1'b0);
      chk($sformatf("t%0d_pv", k), 32'(pv), 1);
      chk($sformatf("t%0d_msb", k), 32'(pout), 32'(tbl[k].msb));
      chk($sformatf("t%0d_lsb", k), 32'(pout_l), 32'(tbl[k].lsb));
      chk($sformatf("t%0d_bc", k), 32'(bc), 0);
      chk($sformatf("t%0d_pe", k), 32'(pe), 0);
      tick();
      chk($sformatf("t%0d_drop", k), 32'(pv), 0);
      chk($sformatf("t%0d_keep", k), 32'(pout), 32'(tbl[k].msb));
    end

    // idle cycles between bits hold state
    for (int i = 7; i >= 0; i--) begin
      send_bit(tbl[6].bits[i]);
      tick();
      if (i == 4) chk("gap_bc", 32'(bc), 4);
    end
`ifdef SIPO_PARITY_EN
    send_bit(^tbl[6].bits);
`endif
    chk("gap_pout", 32'(pout), 32'hC4);
    tick();

    // overrun under backpressure
    pout_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    chk("ovr_pv1", 32'(pv), 1);
    chk("ovr_pout1", 32'(pout), 32'hA5);
    chk("ovr_pre", 32'(ovr), 0);
    send_word(8'h3C, 1'b0);
    chk("ovr_hold", 32'(pout), 32'hA5);
    chk("ovr_pv2", 32'(pv), 1);
    chk("ovr_set", 32'(ovr), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr), 0);
    chk("ovr_stable", 32'(pout), 32'hA5);
    pout_ready = 1'b1;
    tick();
    chk("ovr_drain", 32'(pv), 0);

    // back-to-back drain and load on the same edge
    pout_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    chk("b2b_pv1", 32'(pv), 1);
    send_word(8'h3C, 1'b1);
    chk("b2b_pv2", 32'(pv), 1);
    chk("b2b_pout", 32'(pout), 32'h3C);
    chk("b2b_ovr", 32'(ovr), 0);
    tick();
    chk("b2b_drain", 32'(pv), 0);

    // frame_clr aborts a partial word
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("fc_bc5", 32'(bc), 5);
    frame_clr = 1'b1;
    sin = 1'b1;
    sin_valid = 1'b1;
    tick();
    frame_clr = 1'b0;
    sin_valid = 1'b0;
    chk("fc_bc0", 32'(bc), 0);
    chk("fc_pv", 32'(pv), 0);
    send_word(8'hFF, 1'b0);
    chk("fc_pout", 32'(pout), 32'hFF);
    chk("fc_pv2", 32'(pv), 1);
    tick();

    // set wins over ovr_clr, then reset mid-word
    pout_ready = 1'b0;
    send_word(8'h11, 1'b0);
    ovr_clr = 1'b1;
    send_word(8'h22, 1'b0);
    ovr_clr = 1'b0;
    chk("prio_ovr", 32'(ovr), 1);
    chk("prio_pout", 32'(pout), 32'h11);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid_bc", 32'(bc), 3);
    rst_n = 1'b0;
    tick();
    chk("mr_pout", 32'(pout), 0);
    chk("mr_pv", 32'(pv), 0);
    chk("mr_bc", 32'(bc), 0);
    chk("mr_ovr", 32'(ovr), 0);
    chk("mr_pe", 32'(pe), 0);
    rst_n = 1'b1;
    pout_ready = 1'b1;

`ifdef SIPO_PARITY_EN
    // good parity
    send_data(8'hB2, 1'b0);
    chk("par_bc8", 32'(bc), 8);
    send_bit(1'b0);
    chk("par_pv0", 32'(pv), 1);
    chk("par_pout0", 32'(pout), 32'hB2);
    chk("par_ok", 32'(pe), 0);
    tick();
    // bad parity
    send_data(8'hB2, 1'b0);
    send_bit(1'b1);
    chk("par_pv1", 32'(pv), 1);
    chk("par_bad", 32'(pe), 1);
    tick();
    chk("par_drop", 32'(pe), 0);
    // abort in S_PAR
    send_data(8'hB2, 1'b0);
    frame_clr = 1'b1;
    sin = 1'b0;
    sin_valid = 1'b1;
    tick();
    frame_clr = 1'b0;
    sin_valid = 1'b0;
    chk("par_fc_bc", 32'(bc), 0);
    tick();
    chk("par_fc_pv", 32'(pv), 0);
    send_word(8'h5A, 1'b0);
    chk("par_after", 32'(pout), 32'h5A);
    chk("par_after_pe", 32'(pe), 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out deserializer. It sits directly downstream of the team's single-bit D flip-flop stage and consumes that stage's registered serial bit stream.
- Shifts in WIDTH qualified bits and presents each completed word on a parallel output register under a valid/ready handshake.
- Flags words lost to backpressure with a sticky overrun bit.
- Builds its shift chain from one-bit D flip-flop cells with enable and reset.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in pout[WIDTH-1]; 0 = first received bit lands in pout[0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when 1.
- frame_clr  input  1  aborts the partial word.
- pout  output  WIDTH  completed parallel word.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout this edge.
- bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current word.
- overrun  output  1  sticky: a completed word was dropped.
- ovr_clr  input  1  clears overrun.
- parity_err  output  1  parity result qualified by pout_valid; tied 0 without the macro.

Behaviour:
- Reset (rst_n=0 at an edge): shift register, pout, pout_valid, bit_cnt, overrun and parity_err all go to 0; FSM goes to S_SHIFT. Reset is honoured mid-word and mid-handshake, and any held word is discarded.
- Shift:
  - On an edge with sin_valid=1 and frame_clr=0: MSB_FIRST=1 gives sh <= {sh[WIDTH-2:0], sin}; MSB_FIRST=0 gives sh <= {sin, sh[WIDTH-1:1]}.
  - bit_cnt increments on each such edge.
  - sin_valid=0 holds all state.
- Word completion:
  - Completion is the edge that accepts a bit while bit_cnt==WIDTH-1.
  - On that edge, the completed word (including the bit just sampled) is offered to the holding register.
  - bit_cnt returns to 0 and the shift register is not cleared.
  - pout_valid=1 in the cycle after that edge, giving a latency of 1 clock from the last bit's sample edge.
- Holding register (load_ok = !pout_valid || pout_ready):
  - If load_ok, pout is loaded and pout_valid=1. A simultaneous drain and load is lossless back-to-back.
  - If !load_ok, the new word is dropped, pout and pout_valid are unchanged, and overrun <= 1.
  - If pout_valid && pout_ready with no load on the same edge, pout_valid <= 0 and pout keeps its last value.
  - pout is stable while pout_valid && !pout_ready.
- frame_clr:
  - Has priority over sin_valid. It zeroes bit_cnt and the shift register and returns the FSM to S_SHIFT.
  - The holding register, pout_valid and overrun are unaffected.
- overrun: set has priority over ovr_clr on the same edge.
- FSM (encoding in package):
  - S_SHIFT: collecting data bits.
  - S_PAR: exists only with the macro; waiting for the parity bit.
  - Without the macro the FSM stays in S_SHIFT and completion follows the rule above.
- No combinational path from any input to any output. All outputs are registered.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - After WIDTH data bits, the FSM moves S_SHIFT->S_PAR instead of completing.
  - The next sin_valid bit is the even-parity bit.
  - Completion happens on the parity-bit edge, and parity_err = ^data ^ parity_bit is loaded alongside pout.
  - Overrun rules are unchanged, and frame_clr in S_PAR aborts the word.
- When undefined: parity_err is constant 0 and there is no S_PAR logic.

Decomposition:
- Package sipo_pkg holds:
  - the state typedef {S_SHIFT, S_PAR};
  - the parity-type constant EVEN_PARITY=0;
  - a function computing the counter width from WIDTH.
- Sub-module d_ff_en_rst: one-bit D flip-flop with synchronous active-low reset and enable, outputs q and qbar.
  - The shift chain is WIDTH generate instances of it, enabled by sin_valid && !frame_clr.
  - The chain is cleared by rst_n or frame_clr.

Test Plan:
- WIDTH=8, MSB_FIRST=1, pout_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive edges -> pout=8'hB2, pout_valid=1 for exactly 1 cycle starting the cycle after the 8th edge, bit_cnt back to 0.
- MSB_FIRST=0, same bit stream -> pout=8'h4D.
- pout_ready=0, send word 8'hA5 then 8'h3C -> pout stays 8'hA5, overrun=1; pulse ovr_clr -> overrun=0; raise pout_ready -> pout_valid drops next edge.
- Back-to-back: pout_ready=1 on the same edge the second word completes -> pout changes 8'hA5->8'h3C with pout_valid continuously 1 and overrun=0.
- Send 5 bits, assert frame_clr with sin_valid=1 -> bit_cnt=0; the next 8 bits 8'hFF give pout=8'hFF; assert rst_n=0 mid-word -> all outputs 0 next cycle.
- With SIPO_PARITY_EN: data 8'hB2 (4 ones) + parity bit 0 -> parity_err=0; parity bit 1 -> parity_err=1; frame_clr in S_PAR -> no word delivered.
